// File: rtl/id_pair_issue_pkg.sv
// Shared constants, state encoding and slot-validity rule for the fetch-to-decode pair issue stage.
package id_pair_issue_pkg;

  localparam int          EXCP_W       = 7;
  localparam logic [31:0] PC_RESET_DEF = 32'h1c00_0000;
  localparam logic [31:0] INST_NOP_DEF = 32'h0340_0000;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_HALF  = 2'd2
  } state_t;

  // Slot1 is live only for a fault-free packet starting on an even slot whose
  // predicted successor is not the slot1 address itself (taken branch in slot0).
  function automatic logic slot1_live(input logic        excp_flag,
                                      input logic [31:0] pc,
                                      input logic [31:0] pc_next);
    return !excp_flag && !pc[2] && (pc_next != pc + 32'd4);
  endfunction

endpackage

// File: rtl/id_pair_issue_if.sv
// Fetch-buffer head and decode-slot signals shared by the pair issue stage and its neighbours.
interface id_pair_issue_if;
  import id_pair_issue_pkg::*;

  logic              fetch_buf_empty;
  logic [31:0]       fifo_inst0;
  logic [31:0]       fifo_inst1;
  logic [31:0]       fifo_pc;
  logic [31:0]       fifo_pc_next;
  logic [31:0]       fifo_badv;
  logic [EXCP_W-1:0] fifo_exception;
  logic              fifo_excp_flag;
  logic              fifo_ready;

  logic [1:0]        id_accept;
  logic              id_valid0;
  logic              id_valid1;
  logic [31:0]       id_inst0;
  logic [31:0]       id_inst1;
  logic [31:0]       id_pc0;
  logic [31:0]       id_pc1;
  logic              id_excp_flag;
  logic [EXCP_W-1:0] id_exception;
  logic [31:0]       id_badv;

  modport master (
    output fetch_buf_empty, fifo_inst0, fifo_inst1, fifo_pc, fifo_pc_next,
           fifo_badv, fifo_exception, fifo_excp_flag, id_accept,
    input  fifo_ready, id_valid0, id_valid1, id_inst0, id_inst1, id_pc0,
           id_pc1, id_excp_flag, id_exception, id_badv
  );

  modport slave (
    input  fetch_buf_empty, fifo_inst0, fifo_inst1, fifo_pc, fifo_pc_next,
           fifo_badv, fifo_exception, fifo_excp_flag, id_accept,
    output fifo_ready, id_valid0, id_valid1, id_inst0, id_inst1, id_pc0,
           id_pc1, id_excp_flag, id_exception, id_badv
  );

endinterface

// File: rtl/id_pair_issue.sv
// Skid register between fetch buffer and decode: holds one 2-inst packet and issues 0/1/2 slots
// per cycle as decode accepts them, popping the buffer only when the held packet is drained.
module id_pair_issue
  import id_pair_issue_pkg::*;
#(
  parameter logic [31:0] PC_RESET = PC_RESET_DEF,
  parameter logic [31:0] INST_NOP = INST_NOP_DEF
) (
  input  logic           clk,
  input  logic           rstn,
  input  logic           flush,
  id_pair_issue_if.slave bus
);

  state_t      state;
  logic        v1_p1;
  logic [31:0] inst1_p1;
  logic [31:0] pc1_p1;

  logic [1:0]  remaining;
  logic        consumed;
  logic        split;
  logic        pop;
  logic        cap_v1;

  always_comb begin
    remaining = 2'd0;
    case (state)
      ST_FULL: remaining = v1_p1 ? 2'd2 : 2'd1;
      ST_HALF: remaining = 2'd1;
      default: remaining = 2'd0;
    endcase
    // Over-acceptance is treated as draining the packet.
    consumed = (state != ST_EMPTY) && (bus.id_accept != 2'd0) &&
               (bus.id_accept >= remaining);
    split    = (state == ST_FULL) && v1_p1 && (bus.id_accept == 2'd1);
    pop      = rstn && !flush && !bus.fetch_buf_empty &&
               ((state == ST_EMPTY) || consumed);
    cap_v1   = slot1_live(bus.fifo_excp_flag, bus.fifo_pc, bus.fifo_pc_next);
  end

  assign bus.fifo_ready = pop;

  // ---- stage p1: packet capture, held slot1 payload ----
  always_ff @(posedge clk) begin
    if (pop) begin
      inst1_p1 <= bus.fifo_inst1;
      pc1_p1   <= bus.fifo_pc + 32'd4;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state            <= ST_EMPTY;
      v1_p1            <= 1'b0;
      bus.id_valid0    <= 1'b0;
      bus.id_valid1    <= 1'b0;
      bus.id_inst0     <= INST_NOP;
      bus.id_inst1     <= INST_NOP;
      bus.id_pc0       <= PC_RESET;
      bus.id_pc1       <= PC_RESET;
      bus.id_excp_flag <= 1'b0;
      bus.id_exception <= '0;
      bus.id_badv      <= '0;
    end else if (pop) begin
      state            <= ST_FULL;
      v1_p1            <= cap_v1;
      bus.id_valid0    <= 1'b1;
      bus.id_valid1    <= cap_v1;
      bus.id_inst0     <= bus.fifo_inst0;
      bus.id_inst1     <= cap_v1 ? bus.fifo_inst1 : INST_NOP;
      bus.id_pc0       <= bus.fifo_pc;
      bus.id_pc1       <= bus.fifo_pc + 32'd4;
      bus.id_excp_flag <= bus.fifo_excp_flag;
      bus.id_exception <= bus.fifo_exception;
      bus.id_badv      <= bus.fifo_badv;
    end else if (flush || consumed) begin
      state            <= ST_EMPTY;
      v1_p1            <= 1'b0;
      bus.id_valid0    <= 1'b0;
      bus.id_valid1    <= 1'b0;
      bus.id_inst0     <= INST_NOP;
      bus.id_inst1     <= INST_NOP;
      bus.id_pc0       <= PC_RESET;
      bus.id_pc1       <= PC_RESET;
      bus.id_excp_flag <= 1'b0;
      bus.id_exception <= '0;
      bus.id_badv      <= '0;
    end else if (split) begin
      // Pending slot1 moves down to decode slot0.
      state            <= ST_HALF;
      v1_p1            <= 1'b0;
      bus.id_valid0    <= 1'b1;
      bus.id_valid1    <= 1'b0;
      bus.id_inst0     <= inst1_p1;
      bus.id_inst1     <= INST_NOP;
      bus.id_pc0       <= pc1_p1;
      bus.id_pc1       <= pc1_p1 + 32'd4;
      bus.id_excp_flag <= 1'b0;
      bus.id_exception <= '0;
      bus.id_badv      <= '0;
    end
  end

  a_accept_legal: assert property (@(posedge clk) disable iff (!rstn)
    !flush |-> (bus.id_accept <= remaining));

endmodule

// File: tb/tb_id_pair_issue.sv
// Bench for id_pair_issue: directed vector table, reset and random traffic against a slot-queue model.
module tb_id_pair_issue;
  import id_pair_issue_pkg::*;

  localparam logic [31:0] P   = 32'h1c00_0000;
  localparam logic [31:0] NOP = 32'h0340_0000;

  logic clk   = 1'b0;
  logic rstn  = 1'b0;
  logic flush = 1'b0;

  id_pair_issue_if bus();

  id_pair_issue #(.PC_RESET(P), .INST_NOP(NOP)) dut (
    .clk  (clk),
    .rstn (rstn),
    .flush(flush),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc, pcn, i0, i1, badv;
    logic        xf;
    logic [6:0]  code;
  } pkt_t;

  typedef struct {
    logic [31:0] pc, inst, badv;
    logic        xf;
    logic [6:0]  code;
  } slot_t;

  typedef struct {
    logic        fl, emp;
    logic [1:0]  acc;
    logic [31:0] pc, pcn;
    logic        xf;
    logic        e_rdy, e_v0, e_v1;
    logic [31:0] e_pc0;
    logic        e_xf;
  } vec_t;

  slot_t       q[$];
  int          n_vec = 0;
  int          n_bad = 0;
  logic        s_rdy, s_v0, s_v1, s_xf;
  logic [31:0] s_pc0;
  vec_t        tbl[15];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic pkt_t mkpkt(input logic [31:0] pc, input logic [31:0] pcn, input logic xf);
    pkt_t p;
    p.pc   = pc;
    p.pcn  = pcn;
    p.i0   = {pc[15:0], 16'h0013};
    p.i1   = {pc[15:0], 16'h0093};
    p.xf   = xf;
    p.code = xf ? 7'h08 : 7'h00;
    p.badv = xf ? P + 32'h10 : 32'h0;
    return p;
  endfunction

  // Instructions the packet contributes to decode, in program order.
  task automatic load(input pkt_t pk);
    q.push_back('{pk.pc, pk.i0, pk.badv, pk.xf, pk.code});
    if (!pk.xf && (pk.pc % 8 == 0) && (pk.pcn != pk.pc + 32'd4))
      q.push_back('{pk.pc + 32'd4, pk.i1, 32'h0, 1'b0, 7'h0});
  endtask

  task automatic check_outputs(input logic exp_pop);
    s_rdy = bus.fifo_ready;
    s_v0  = bus.id_valid0;
    s_v1  = bus.id_valid1;
    s_pc0 = bus.id_pc0;
    s_xf  = bus.id_excp_flag;
    chk("fifo_ready", {31'd0, s_rdy}, {31'd0, exp_pop});
    chk("id_valid0", {31'd0, s_v0}, {31'd0, q.size() >= 1});
    chk("id_valid1", {31'd0, s_v1}, {31'd0, q.size() >= 2});
    if (q.size() >= 1) begin
      chk("id_pc0", s_pc0, q[0].pc);
      chk("id_inst0", bus.id_inst0, q[0].inst);
      chk("id_excp_flag", {31'd0, s_xf}, {31'd0, q[0].xf});
      if (q[0].xf) begin
        chk("id_exception", {25'd0, bus.id_exception}, {25'd0, q[0].code});
        chk("id_badv", bus.id_badv, q[0].badv);
      end
    end else begin
      chk("id_pc0_idle", s_pc0, P);
      chk("id_inst0_idle", bus.id_inst0, NOP);
      chk("id_excp_idle", {31'd0, s_xf}, 32'd0);
      chk("id_badv_idle", bus.id_badv, 32'd0);
    end
    if (q.size() >= 2) begin
      chk("id_pc1", bus.id_pc1, q[1].pc);
      chk("id_inst1", bus.id_inst1, q[1].inst);
    end else begin
      chk("id_inst1_nop", bus.id_inst1, NOP);
    end
  endtask

  // Drive one cycle just after a rising edge, check mid-cycle, advance the model at the edge.
  task automatic step(input logic fl, input logic emp, input logic [1:0] acc, input pkt_t pk);
    logic exp_pop;
    flush                = fl;
    bus.fetch_buf_empty  = emp;
    bus.id_accept        = acc;
    bus.fifo_inst0       = pk.i0;
    bus.fifo_inst1       = pk.i1;
    bus.fifo_pc          = pk.pc;
    bus.fifo_pc_next     = pk.pcn;
    bus.fifo_badv        = pk.badv;
    bus.fifo_exception   = pk.code;
    bus.fifo_excp_flag   = pk.xf;
    #3;
    exp_pop = rstn && !fl && !emp && (q.size() == 0 || int'(acc) == q.size());
    check_outputs(exp_pop);
    @(posedge clk);
    if (fl) q.delete();
    else begin
      for (int k = 0; k < int'(acc) && q.size() > 0; k++) void'(q.pop_front());
      if (exp_pop) load(pk);
    end
    #1;
  endtask

  initial begin
    pkt_t pk;
    tbl[0]  = '{1'b0, 1'b1, 2'd0, P,         P + 32'h08, 1'b0, 1'b0, 1'b0, 1'b0, P,          1'b0};
    tbl[1]  = '{1'b0, 1'b0, 2'd0, P,         P + 32'h08, 1'b0, 1'b1, 1'b0, 1'b0, P,          1'b0};
    tbl[2]  = '{1'b0, 1'b0, 2'd2, P + 32'h08, P + 32'h10, 1'b0, 1'b1, 1'b1, 1'b1, P,          1'b0};
    tbl[3]  = '{1'b0, 1'b0, 2'd2, P + 32'h10, P + 32'h18, 1'b0, 1'b1, 1'b1, 1'b1, P + 32'h08, 1'b0};
    tbl[4]  = '{1'b0, 1'b1, 2'd1, P + 32'h20, P + 32'h28, 1'b0, 1'b0, 1'b1, 1'b1, P + 32'h10, 1'b0};
    tbl[5]  = '{1'b0, 1'b0, 2'd0, P + 32'h20, P + 32'h28, 1'b0, 1'b0, 1'b1, 1'b0, P + 32'h14, 1'b0};
    tbl[6]  = '{1'b0, 1'b0, 2'd1, P + 32'h20, P + 32'h28, 1'b0, 1'b1, 1'b1, 1'b0, P + 32'h14, 1'b0};
    tbl[7]  = '{1'b0, 1'b0, 2'd2, P + 32'h44, P + 32'h80, 1'b0, 1'b1, 1'b1, 1'b1, P + 32'h20, 1'b0};
    tbl[8]  = '{1'b0, 1'b0, 2'd1, P + 32'h50, P + 32'h54, 1'b0, 1'b1, 1'b1, 1'b0, P + 32'h44, 1'b0};
    tbl[9]  = '{1'b0, 1'b0, 2'd1, P + 32'h60, P + 32'h68, 1'b1, 1'b1, 1'b1, 1'b0, P + 32'h50, 1'b0};
    tbl[10] = '{1'b0, 1'b0, 2'd0, P + 32'h70, P + 32'h78, 1'b0, 1'b0, 1'b1, 1'b0, P + 32'h60, 1'b1};
    tbl[11] = '{1'b0, 1'b0, 2'd1, P + 32'h70, P + 32'h78, 1'b0, 1'b1, 1'b1, 1'b0, P + 32'h60, 1'b1};
    tbl[12] = '{1'b0, 1'b0, 2'd1, P + 32'h80, P + 32'h88, 1'b0, 1'b0, 1'b1, 1'b1, P + 32'h70, 1'b0};
    tbl[13] = '{1'b1, 1'b0, 2'd2, P + 32'h80, P + 32'h88, 1'b0, 1'b0, 1'b1, 1'b0, P + 32'h74, 1'b0};
    tbl[14] = '{1'b0, 1'b1, 2'd0, P + 32'h80, P + 32'h88, 1'b0, 1'b0, 1'b0, 1'b0, P,          1'b0};

    pk = mkpkt(P, P + 32'h8, 1'b0);
    flush               = 1'b0;
    bus.fetch_buf_empty = 1'b1;
    bus.id_accept       = 2'd0;
    bus.fifo_inst0      = pk.i0;
    bus.fifo_inst1      = pk.i1;
    bus.fifo_pc         = pk.pc;
    bus.fifo_pc_next    = pk.pcn;
    bus.fifo_badv       = 32'h0;
    bus.fifo_exception  = 7'h0;
    bus.fifo_excp_flag  = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    chk("rst_fifo_ready", {31'd0, bus.fifo_ready}, 32'd0);
    chk("rst_id_valid0", {31'd0, bus.id_valid0}, 32'd0);
    chk("rst_id_valid1", {31'd0, bus.id_valid1}, 32'd0);
    chk("rst_id_pc0", bus.id_pc0, P);
    chk("rst_id_inst0", bus.id_inst0, NOP);
    @(posedge clk);
    #1 rstn = 1'b1;

    for (int i = 0; i < 15; i++) begin
      step(tbl[i].fl, tbl[i].emp, tbl[i].acc, mkpkt(tbl[i].pc, tbl[i].pcn, tbl[i].xf));
      chk($sformatf("tbl%0d_ready", i), {31'd0, s_rdy}, {31'd0, tbl[i].e_rdy});
      chk($sformatf("tbl%0d_v0", i), {31'd0, s_v0}, {31'd0, tbl[i].e_v0});
      chk($sformatf("tbl%0d_v1", i), {31'd0, s_v1}, {31'd0, tbl[i].e_v1});
      chk($sformatf("tbl%0d_pc0", i), s_pc0, tbl[i].e_pc0);
      chk($sformatf("tbl%0d_excp", i), {31'd0, s_xf}, {31'd0, tbl[i].e_xf});
    end

    // Reset dropped mid-operation with a packet held and the buffer non-empty.
    step(1'b0, 1'b0, 2'd0, mkpkt(P + 32'h100, P + 32'h108, 1'b0));
    chk("pre_rst_valid0", {31'd0, bus.id_valid0}, 32'd1);
    rstn = 1'b0;
    #2;
    chk("mid_rst_valid0", {31'd0, bus.id_valid0}, 32'd0);
    chk("mid_rst_valid1", {31'd0, bus.id_valid1}, 32'd0);
    chk("mid_rst_ready", {31'd0, bus.fifo_ready}, 32'd0);
    chk("mid_rst_pc0", bus.id_pc0, P);
    chk("mid_rst_inst0", bus.id_inst0, NOP);
    q.delete();
    @(posedge clk);
    #1 rstn = 1'b1;

    for (int n = 0; n < 400; n++) begin
      logic        fl, emp;
      logic [1:0]  acc;
      int          sel;
      pk.pc   = P + 32'($urandom_range(0, 255)) * 32'd4;
      sel     = $urandom_range(0, 2);
      pk.pcn  = (sel == 0) ? pk.pc + 32'd4 :
                (sel == 1) ? pk.pc + 32'd8 : P + 32'($urandom_range(0, 1023)) * 32'd4;
      pk.i0   = $urandom;
      pk.i1   = $urandom;
      pk.xf   = ($urandom_range(0, 7) == 0);
      pk.code = 7'($urandom_range(1, 127));
      pk.badv = $urandom;
      fl      = ($urandom_range(0, 15) == 0);
      emp     = ($urandom_range(0, 3) == 0);
      acc     = fl ? 2'($urandom_range(0, 2)) : 2'($urandom_range(0, q.size()));
      step(fl, emp, acc, pk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
